// File: rtl/traffic_pkg.sv
// Shared light codes and phase encoding for the multi-approach traffic-light controller.
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b10;
    localparam logic [1:0] LIGHT_YELLOW = 2'b11;
    localparam logic [1:0] LIGHT_GREEN  = 2'b01;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_t;

endpackage

// File: rtl/btn_release_det.sv
// Two-flop synchroniser on the raw button plus a registered 1->0 (release) detector.
module btn_release_det (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic release_pulse
);

    logic sync1;
    logic sync2;

    // Pulse fires on the same edge the synced level drops from 1 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= btn;
            sync2         <= sync1;
            release_pulse <= sync2 & ~sync1;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin N-approach traffic-light controller: timed GREEN/YELLOW/ALLRED phases,
// manual green release, and emergency all-red override.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned N_DIR        = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned GREEN_TICKS  = 50,
    parameter int unsigned YELLOW_TICKS = 10,
    parameter int unsigned ALLRED_TICKS = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       mode_manual,
    input  logic                       btn,
    input  logic                       emergency,
    output logic [2*N_DIR-1:0]         lights,
    output logic [$clog2(N_DIR)-1:0]   active_dir,
    output logic [1:0]                 phase
);

    localparam int unsigned DIR_W = $clog2(N_DIR);
    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] A_LAST   = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(N_DIR - 1);

    phase_t              phase_q;
    phase_t              phase_n;
    logic [DIR_W-1:0]    dir_q;
    logic [DIR_W-1:0]    dir_n;
    logic [CNT_W-1:0]    timer_q;
    logic [CNT_W-1:0]    timer_n;
    logic [2*N_DIR-1:0]  lights_n;
    logic                release_pulse;

    btn_release_det u_btn (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .release_pulse (release_pulse)
    );

    // State register; reset is folded into the next-state logic (synchronous).
    always_ff @(posedge clk) begin
        phase_q <= phase_n;
        dir_q   <= dir_n;
        timer_q <= timer_n;
        lights  <= lights_n;
    end

    assign phase      = phase_q;
    assign active_dir = dir_q;

    // Next-state: reset first, then emergency/release, then tick-timed progress.
    always_comb begin
        phase_n = phase_q;
        dir_n   = dir_q;
        timer_n = timer_q;

        if (rst) begin
            phase_n = PH_GREEN;
            dir_n   = '0;
            timer_n = '0;
        end else begin
            case (phase_q)
                PH_GREEN: begin
                    if (emergency || (mode_manual && release_pulse)) begin
                        phase_n = PH_YELLOW;
                        timer_n = '0;
                    end else if (!mode_manual && tick) begin
                        // >= so a value held over from manual mode still ends green.
                        if (timer_q >= G_LAST) begin
                            phase_n = PH_YELLOW;
                            timer_n = '0;
                        end else begin
                            timer_n = timer_q + CNT_W'(1);
                        end
                    end
                end
                PH_YELLOW: begin
                    if (tick) begin
                        if (timer_q >= Y_LAST) begin
                            phase_n = PH_ALLRED;
                            timer_n = '0;
                        end else begin
                            timer_n = timer_q + CNT_W'(1);
                        end
                    end
                end
                PH_ALLRED: begin
                    if (emergency) begin
                        timer_n = '0;
                    end else if (tick) begin
                        if (timer_q >= A_LAST) begin
                            phase_n = PH_GREEN;
                            timer_n = '0;
                            dir_n   = (dir_q == DIR_LAST) ? '0 : dir_q + DIR_W'(1);
                        end else begin
                            timer_n = timer_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    phase_n = PH_ALLRED;
                    timer_n = '0;
                end
            endcase
        end
    end

    // Lamp decode from the next state so lights stay aligned with phase/active_dir.
    always_comb begin
        lights_n = {N_DIR{LIGHT_RED}};
        for (int i = 0; i < int'(N_DIR); i++) begin
            if (dir_n == DIR_W'(i)) begin
                if (phase_n == PH_GREEN) begin
                    lights_n[2*i +: 2] = LIGHT_GREEN;
                end else if (phase_n == PH_YELLOW) begin
                    lights_n[2*i +: 2] = LIGHT_YELLOW;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: driver queues hand-derived expectations per
// clock edge, an independent monitor pops and compares after each edge.
module tb_traffic_light_ctrl;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       mode_manual;
    logic       btn;
    logic       emergency;
    logic [7:0] lights;
    logic [1:0] active_dir;
    logic [1:0] phase;

    typedef struct packed {
        logic [7:0] lights;
        logic [1:0] phase;
        logic [1:0] dir;
    } exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step   = 0;

    traffic_light_ctrl #(
        .N_DIR        (4),
        .CNT_W        (16),
        .GREEN_TICKS  (5),
        .YELLOW_TICKS (2),
        .ALLRED_TICKS (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .mode_manual (mode_manual),
        .btn         (btn),
        .emergency   (emergency),
        .lights      (lights),
        .active_dir  (active_dir),
        .phase       (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] lt(input logic [1:0] ph, input logic [1:0] d);
        logic [7:0] v;
        v = 8'b10_10_10_10;
        if (ph == 2'b00) v[2*d +: 2] = 2'b01;
        else if (ph == 2'b01) v[2*d +: 2] = 2'b11;
        return v;
    endfunction

    // Queue the state expected after the next rising edge, then move to the next negedge.
    task automatic push(input logic [7:0] l, input logic [1:0] ph, input logic [1:0] d);
        exp_t e;
        e.lights = l;
        e.phase  = ph;
        e.dir    = d;
        exp_q.push_back(e);
        id_q.push_back(step);
        step++;
        @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] ph, input logic [1:0] d, input int n);
        repeat (n) push(lt(ph, d), ph, d);
    endtask

    // Monitor: one output word per edge, compared against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        int   id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                checks++;
                if ({lights, phase, active_dir} !== e) begin
                    errors++;
                    $display("FAIL step %0d: got lights=%b phase=%b dir=%0d, want lights=%b phase=%b dir=%0d",
                             id, lights, phase, active_dir, e.lights, e.phase, e.dir);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b1; mode_manual = 1'b0; btn = 1'b0; emergency = 1'b0;

        // Reset state.
        push(8'b10_10_10_01, 2'b00, 2'd0);
        rst = 1'b0;

        // Auto cycle: 5 green, 2 yellow, 1 all-red per approach, wrapping to 0.
        hold(2'b00, 2'd0, 4);
        hold(2'b01, 2'd0, 2);
        push(8'b10_10_10_10, 2'b10, 2'd0);
        push(8'b10_10_01_10, 2'b00, 2'd1);
        hold(2'b00, 2'd1, 4);
        hold(2'b01, 2'd1, 2);
        hold(2'b10, 2'd1, 1);
        for (int d = 2; d < 4; d++) begin
            hold(2'b00, 2'(d), 5);
            hold(2'b01, 2'(d), 2);
            hold(2'b10, 2'(d), 1);
        end
        push(8'b10_10_10_01, 2'b00, 2'd0);

        // Manual: green held, release advances on 3rd edge, release during yellow dropped.
        mode_manual = 1'b1;
        hold(2'b00, 2'd0, 100);
        btn = 1'b1;
        hold(2'b00, 2'd0, 4);
        btn = 1'b0;
        hold(2'b00, 2'd0, 1);
        btn = 1'b1;
        hold(2'b00, 2'd0, 1);
        btn = 1'b0;
        push(8'b10_10_10_11, 2'b01, 2'd0);
        hold(2'b01, 2'd0, 1);
        hold(2'b10, 2'd0, 1);
        hold(2'b00, 2'd1, 30);

        // Emergency mid-green: yellow next edge, all-red held, then next approach.
        mode_manual = 1'b0;
        hold(2'b00, 2'd1, 2);
        emergency = 1'b1;
        hold(2'b01, 2'd1, 2);
        hold(2'b10, 2'd1, 20);
        emergency = 1'b0;
        push(8'b10_01_10_10, 2'b00, 2'd2);

        // Tick every 3rd cycle: green lasts 15 cycles; tick=0 freezes yellow.
        for (int k = 1; k < 15; k++) begin
            tick = ((k % 3) == 0);
            hold(2'b00, 2'd2, 1);
        end
        tick = 1'b1;
        push(8'b10_11_10_10, 2'b01, 2'd2);
        tick = 1'b0;
        hold(2'b01, 2'd2, 40);

        // Reset during yellow of approach 2.
        rst = 1'b1;
        push(8'b10_10_10_01, 2'b00, 2'd0);
        rst = 1'b0;
        tick = 1'b1;
        hold(2'b00, 2'd0, 2);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
